dmem_responder: RTL and testbench

- Data-memory target for the core's load/store port. The core issues requests; this block services them.
- Accepts one request at a time over a valid/ready handshake.
- Applies a programmable wait-state latency, then performs a byte, halfword or word read or write on an internal word-addressed array.
- Returns a response over a valid/ready handshake, with sign or zero extension for loads and an error flag for misaligned or out-of-range accesses.

---
 rtl/dmem_responder_pkg.sv | 26 ++
 rtl/dmem_responder_mem_lane_align.sv | 64 ++++++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// FSM state encoding and the latched request record.
package dmem_responder_pkg;

  localparam logic [1:0] MEM_B   = 2'b00;
  localparam logic [1:0] MEM_H   = 2'b01;
  localparam logic [1:0] MEM_W   = 2'b10;
  localparam logic [1:0] MEM_BAD = 2'b11;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    DM_IDLE = 2'b00,
    DM_WAIT = 2'b01,
    DM_RESP = 2'b10
  } dm_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        is_unsigned;
  } dm_req_t;

endpackage

// File: rtl/dmem_responder_mem_lane_align.sv
// Byte-lane steering for one 32-bit word: load extraction with sign/zero
// extension, store merge into the existing word, and alignment check.
module mem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o,
  output logic        misalign_o
);

  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic        sign_b;
  logic        sign_h;

  always_comb begin
    shifted = word_i >> {addr_i, 3'b000};
    sign_b  = ~unsigned_i & shifted[7];
    sign_h  = ~unsigned_i & shifted[15];
    case (size_i)
      MEM_B:   load_o = {{24{sign_b}}, shifted[7:0]};
      MEM_H:   load_o = {{16{sign_h}}, shifted[15:0]};
      default: load_o = word_i;
    endcase
  end

  // Replicate store data across lanes so the mask alone picks the target bytes.
  always_comb begin
    case (size_i)
      MEM_B: begin
        lane_mask = 32'h0000_00ff << {addr_i, 3'b000};
        lane_data = {4{wdata_i[7:0]}};
      end
      MEM_H: begin
        lane_mask = 32'h0000_ffff << {addr_i[1], 4'b0000};
        lane_data = {2{wdata_i[15:0]}};
      end
      MEM_W: begin
        lane_mask = 32'hffff_ffff;
        lane_data = wdata_i;
      end
      default: begin
        lane_mask = 32'h0000_0000;
        lane_data = 32'h0000_0000;
      end
    endcase
    store_o = (word_i & ~lane_mask) | (lane_data & lane_mask);
  end

  always_comb begin
    case (size_i)
      MEM_H:   misalign_o = addr_i[0];
      MEM_W:   misalign_o = |addr_i;
      default: misalign_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the core load/store port: one request at a time,
// programmable wait states, then a byte/halfword/word access on a word array.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; valid is never withdrawn before that edge and the
  // response payload stays frozen while resp_valid is high.

  dm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dm_req_t          req_q, req_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  dm_req_t     req_in;
  dm_req_t     acc;
  logic        accept;
  logic        enter_resp;
  logic [AW-1:0] widx;
  logic [31:0] rd_word;
  logic [31:0] load_val;
  logic [31:0] store_word;
  logic        misalign;
  logic        out_of_range;
  logic        acc_err;

  assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata,
                    size: req_size, is_unsigned: req_unsigned};
  assign accept = req_valid & req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DM_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      DM_IDLE: begin
        if (accept) begin
          req_d   = req_in;
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? DM_RESP : DM_WAIT;
        end
      end
      DM_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 1) state_d = DM_RESP;
      end
      DM_RESP: begin
        if (resp_ready) state_d = DM_IDLE;
      end
      default: state_d = DM_IDLE;
    endcase
  end

  // With a one-cycle latency the access happens on the acceptance edge,
  // before the request has been latched, so take fields from the port.
  assign enter_resp   = (state_d == DM_RESP) && (state_q != DM_RESP);
  assign acc          = (state_q == DM_IDLE) ? req_in : req_q;
  assign widx         = acc.addr[AW+1:2];
  assign rd_word      = mem_q[widx];
  assign out_of_range = {2'b00, acc.addr[31:2]} >= DEPTH_L;
  assign acc_err      = (acc.size == MEM_BAD) | misalign | out_of_range;

  mem_lane_align u_align (
    .word_i     (rd_word),
    .addr_i     (acc.addr[1:0]),
    .size_i     (acc.size),
    .unsigned_i (acc.is_unsigned),
    .wdata_i    (acc.wdata),
    .load_o     (load_val),
    .store_o    (store_word),
    .misalign_o (misalign)
  );

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_err | acc.we) ? 32'h0 : load_val;
    end
  end

  // Array has no reset; a write is suppressed whenever reset is low.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && acc.we && !acc_err) begin
      mem_q[widx] <= store_word;
    end
  end

  always_comb begin
    req_ready  = reset & (state_q == DM_IDLE);
    resp_valid = (state_q == DM_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder: a LATENCY=2 instance
// for the main scenarios and a LATENCY=1 instance for back-to-back streaming.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [1:0]  req_size, dbg_state;
  logic        resp_valid, resp_ready, resp_err;

  logic        req_valid1, req_ready1, req_we1, req_unsigned1;
  logic [31:0] req_addr1, req_wdata1, resp_rdata1;
  logic [1:0]  req_size1, dbg_state1;
  logic        resp_valid1, resp_ready1, resp_err1;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .req_size(req_size1), .req_unsigned(req_unsigned1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1), .dbg_state(dbg_state1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory image per instance; only words 0..15 are ever written.
  logic [31:0] ref_mem [2][16];
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input int inst, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] size,
                                input logic uns, output logic [31:0] rd, output logic err);
    int nb, off;
    logic [31:0] w, v;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr % 4);
    err = (size == 2'b11) || ((addr % nb) != 0) || ((addr >> 2) >= DEPTH);
    rd  = 32'h0;
    if (err) return;
    w = ref_mem[inst][addr >> 2];
    if (we) begin
      for (int b = 0; b < nb; b++) w[8*(off+b) +: 8] = wdata[8*b +: 8];
      ref_mem[inst][addr >> 2] = w;
    end else begin
      v = 32'h0;
      for (int b = 0; b < nb; b++) v[8*b +: 8] = w[8*(off+b) +: 8];
      if (!uns && nb < 4 && v[8*nb-1]) begin
        for (int b = nb; b < 4; b++) v[8*b +: 8] = 8'hff;
      end
      rd = v;
    end
  endfunction

  task automatic rand_fields(output logic we, output logic [31:0] addr, output logic [31:0] wdata,
                             output logic [1:0] size, output logic uns);
    we    = 1'($urandom_range(0, 1));
    size  = 2'($urandom_range(0, 3));
    uns   = 1'($urandom_range(0, 1));
    wdata = $urandom;
    if ($urandom_range(0, 7) == 0)
      addr = (DEPTH * 4) + $urandom_range(0, 4095);
    else
      addr = ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input int stall,
                        output logic [31:0] got, output logic got_err);
    logic [31:0] erd, hold;
    logic        eerr;
    int          n;
    model(0, we, addr, wdata, size, uns, erd, eerr);
    @(posedge clk); #1;
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size;
    req_unsigned = uns; req_valid = 1'b1; resp_ready = (stall == 0);
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("idle_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    // Scramble request fields after acceptance; they must be ignored.
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_size = 2'($urandom); req_unsigned = 1'($urandom);
    n = 1;
    @(negedge clk);
    while (!resp_valid && n < 40) begin
      check("busy_req_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(LAT));
    check("resp_rdata", resp_rdata, erd);
    check("resp_err", 32'(resp_err), 32'(eerr));
    got = resp_rdata; got_err = resp_err; hold = resp_rdata;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'h1);
      check("hold_rdata", resp_rdata, hold);
      check("hold_req_ready", 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("post_hs_valid", 32'(resp_valid), 32'h0);
    check("post_hs_ready", 32'(req_ready), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got, a, wd;
    logic        gerr, we, uns;
    logic [1:0]  sz;
    logic [32:0] e;
    int          last_resp;

    reset = 1'b0;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0;
    resp_ready = 0;
    req_valid1 = 0; req_we1 = 0; req_addr1 = 0; req_wdata1 = 0; req_size1 = 0; req_unsigned1 = 0;
    resp_ready1 = 0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'h0);
    check("rst_req_ready1", 32'(req_ready1), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_req_ready", 32'(req_ready), 32'h1);

    for (int i = 0; i < 16; i++) do_req(1'b1, 32'(i * 4), $urandom, MEM_W, 1'b0, 0, got, gerr);

    do_req(1'b1, 32'h10, 32'hdeadbeef, MEM_W, 1'b0, 0, got, gerr);
    check("s1_store_rdata", got, 32'h0);
    do_req(1'b0, 32'h10, 32'h0, MEM_W, 1'b0, 0, got, gerr);
    check("s1_load_w", got, 32'hdeadbeef);

    do_req(1'b1, 32'h11, 32'h80, MEM_B, 1'b0, 0, got, gerr);
    do_req(1'b0, 32'h10, 32'h0, MEM_W, 1'b0, 0, got, gerr);
    check("s2_word_after_sb", got, 32'hdead80ef);
    do_req(1'b0, 32'h11, 32'h0, MEM_B, 1'b0, 0, got, gerr);
    check("s2_lb", got, 32'hffffff80);
    do_req(1'b0, 32'h11, 32'h0, MEM_B, 1'b1, 0, got, gerr);
    check("s2_lbu", got, 32'h00000080);
    do_req(1'b0, 32'h12, 32'h0, MEM_H, 1'b0, 0, got, gerr);
    check("s2_lh", got, 32'hffffdead);

    do_req(1'b1, 32'h13, 32'hffff, MEM_H, 1'b0, 0, got, gerr);
    check("s3_sh_misalign_err", 32'(gerr), 32'h1);
    do_req(1'b0, 32'h10, 32'h0, MEM_W, 1'b0, 0, got, gerr);
    check("s3_word_unchanged", got, 32'hdead80ef);
    do_req(1'b0, 32'(DEPTH * 4), 32'h0, MEM_W, 1'b0, 0, got, gerr);
    check("s3_oor_err", 32'(gerr), 32'h1);

    do_req(1'b0, 32'h10, 32'h0, MEM_W, 1'b0, 5, got, gerr);
    check("s4_stall_load", got, 32'hdead80ef);

    // Reset in WAIT: the store to 0x20 must be dropped.
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_size = MEM_W;
    req_unsigned = 1'b0; req_valid = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    check("s5_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("s5_in_wait", 32'(dbg_state), 32'(DM_WAIT));
    reset = 1'b0;
    #1;
    check("s5_rst_req_ready", 32'(req_ready), 32'h0);
    check("s5_rst_valid", 32'(resp_valid), 32'h0);
    check("s5_rst_rdata", resp_rdata, 32'h0);
    check("s5_rst_err", 32'(resp_err), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("s5_rel_ready", 32'(req_ready), 32'h1);
    do_req(1'b0, 32'h20, 32'h0, MEM_W, 1'b0, 0, got, gerr);

    for (int i = 0; i < 40; i++) begin
      rand_fields(we, a, wd, sz, uns);
      do_req(we, a, wd, sz, uns, $urandom_range(0, 3), got, gerr);
    end

    // LATENCY=1 instance: stream requests with req_valid held high.
    @(posedge clk); #1;
    resp_ready1 = 1'b1;
    req_valid1  = 1'b1;
    last_resp   = -1;
    for (int k = 0; k < 40; k++) begin
      if (k < 16) begin
        we = 1'b1; a = 32'(k * 4); wd = $urandom; sz = MEM_W; uns = 1'b0;
      end else begin
        rand_fields(we, a, wd, sz, uns);
      end
      req_we1 = we; req_addr1 = a; req_wdata1 = wd; req_size1 = sz; req_unsigned1 = uns;
      model(1, we, a, wd, sz, uns, got, gerr);
      exp_q.push_back({gerr, got});
      @(negedge clk);
      check("l1_req_ready", 32'(req_ready1), 32'h1);
      @(posedge clk); #1;
      @(negedge clk);
      check("l1_resp_valid", 32'(resp_valid1), 32'h1);
      check("l1_busy_ready", 32'(req_ready1), 32'h0);
      e = exp_q.pop_front();
      check("l1_rdata", resp_rdata1, e[31:0]);
      check("l1_err", 32'(resp_err1), 32'(e[32]));
      if (last_resp >= 0) check("l1_period", 32'(cyc - last_resp), 32'h2);
      last_resp = cyc;
      @(posedge clk); #1;
    end
    req_valid1 = 1'b0;
    @(negedge clk);
    check("l1_idle_valid", 32'(resp_valid1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
